// File: rtl/uart_rx_pkg.sv
// Shared types, limits and frame-length helper for the UART receive timing path.
// Latency: n/a (package only).
// Backpressure: n/a.
package uart_rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    // data_sel encodings
    localparam logic [1:0] DSEL_5 = 2'b00;
    localparam logic [1:0] DSEL_6 = 2'b01;
    localparam logic [1:0] DSEL_7 = 2'b10;
    localparam logic [1:0] DSEL_8 = 2'b11;

    localparam int MIN_PRESCALE  = 4;
    localparam int MAX_FRAME_LEN = 12;
    localparam int FLEN_W        = $clog2(MAX_FRAME_LEN + 1);

    // Total bits in a frame: start + data + optional parity + 1 or 2 stop.
    function automatic logic [FLEN_W-1:0] frame_len(input logic [1:0] dsel,
                                                    input logic       par,
                                                    input logic       two_stop);
        logic [FLEN_W-1:0] d;
        case (dsel)
            DSEL_5:  d = FLEN_W'(5);
            DSEL_6:  d = FLEN_W'(6);
            DSEL_7:  d = FLEN_W'(7);
            DSEL_8:  d = FLEN_W'(8);
            default: d = FLEN_W'(8);
        endcase
        return FLEN_W'(1) + d + FLEN_W'(par) + (two_stop ? FLEN_W'(2) : FLEN_W'(1));
    endfunction

endpackage

// File: rtl/uart_rx_sample_gen.sv
// Decodes prescale and edge index into the 3-strobe sample window and bit_done.
// Latency: purely combinational; the parent registers the results.
// Backpressure: none.
// Ports: active (counting), prescale (P), edge_cnt -> sample_pulse, sample_idx, bit_done.
module uart_rx_sample_gen #(
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      active,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    input  logic [PRESCALE_WIDTH-1:0] edge_cnt,
    output logic                      sample_pulse,
    output logic [1:0]                sample_idx,
    output logic                      bit_done
);
    localparam logic [PRESCALE_WIDTH-1:0] ONE = PRESCALE_WIDTH'(1);

    logic [PRESCALE_WIDTH-1:0] center;
    logic [PRESCALE_WIDTH-1:0] p_last;

    always_comb begin
        // Floor of P/2: odd P puts the window half an edge early.
        center       = prescale >> 1;
        p_last       = prescale - ONE;
        sample_pulse = 1'b0;
        sample_idx   = 2'd0;
        bit_done     = 1'b0;
        if (active) begin
            if (edge_cnt == center - ONE) begin
                sample_pulse = 1'b1;
                sample_idx   = 2'd0;
            end else if (edge_cnt == center) begin
                sample_pulse = 1'b1;
                sample_idx   = 2'd1;
            end else if (edge_cnt == center + ONE) begin
                sample_pulse = 1'b1;
                sample_idx   = 2'd2;
            end
            bit_done = (edge_cnt == p_last);
        end
    end

endmodule

// File: rtl/uart_rx_frame_timer.sv
// Oversampling edge/bit timer for UART RX with runtime frame format (5-8N/E/O, 1-2 stop).
// Latency: registered outputs; busy/edge_cnt=0/bit_cnt=0 one cycle after enable is taken in IDLE.
// Backpressure: none; enable low aborts to IDLE on the next cycle.
// Ports: clk, reset_n (sync, active-low), enable, Prescale, data_sel, par_en, stop2,
//        [rx_resync when UART_RX_FRAME_TIMER_RESYNC_EN is defined]
//        -> edge_cnt, bit_cnt, sample_pulse, sample_idx, bit_done, frame_done, busy, cfg_err.
module uart_rx_frame_timer #(
    parameter int PRESCALE_WIDTH = 6,
    parameter int N_BITS         = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      enable,
    input  logic [PRESCALE_WIDTH-1:0] Prescale,
    input  logic [1:0]                data_sel,
    input  logic                      par_en,
    input  logic                      stop2,
`ifdef UART_RX_FRAME_TIMER_RESYNC_EN
    input  logic                      rx_resync,
`endif
    output logic [PRESCALE_WIDTH-1:0] edge_cnt,
    output logic [N_BITS-1:0]         bit_cnt,
    output logic                      sample_pulse,
    output logic [1:0]                sample_idx,
    output logic                      bit_done,
    output logic                      frame_done,
    output logic                      busy,
    output logic                      cfg_err
);
    import uart_rx_pkg::*;

    localparam logic [PRESCALE_WIDTH-1:0] ONE_E = PRESCALE_WIDTH'(1);
    localparam logic [N_BITS-1:0]         ONE_B = N_BITS'(1);

    state_t                    state, state_n;
    logic [PRESCALE_WIDTH-1:0] p_q;
    logic [1:0]                dsel_q;
    logic                      par_q, stop2_q;

    logic [PRESCALE_WIDTH-1:0] edge_n, p_act, p_last;
    logic [N_BITS-1:0]         bit_n, len_m1;
    logic                      frame_n, cfg_n, resync_hit, start;
    logic                      sp_n, bd_n;
    logic [1:0]                si_n;

    always_comb begin
        state_n = state;
        edge_n  = '0;
        bit_n   = '0;
        cfg_n   = cfg_err;
        start   = 1'b0;
        p_last  = p_q - ONE_E;
        len_m1  = N_BITS'(frame_len(dsel_q, par_q, stop2_q)) - ONE_B;
`ifdef UART_RX_FRAME_TIMER_RESYNC_EN
        resync_hit = rx_resync && (bit_cnt == '0);
`else
        resync_hit = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (enable) begin
                    if (Prescale >= PRESCALE_WIDTH'(MIN_PRESCALE)) begin
                        start   = 1'b1;
                        cfg_n   = 1'b0;
                        state_n = ST_COUNT;
                    end else begin
                        cfg_n   = 1'b1;
                        state_n = ST_HOLD;
                    end
                end
            end
            ST_COUNT: begin
                if (!enable) begin
                    state_n = ST_IDLE;
                end else if (edge_cnt == p_last && bit_cnt == len_m1) begin
                    state_n = ST_HOLD;
                end else if (resync_hit) begin
                    // Re-centre the start bit: restart its edge count, stay on bit 0.
                    bit_n = bit_cnt;
                end else if (edge_cnt == p_last) begin
                    bit_n = bit_cnt + ONE_B;
                end else begin
                    edge_n = edge_cnt + ONE_E;
                    bit_n  = bit_cnt;
                end
            end
            ST_HOLD: begin
                if (!enable) state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase

        // Decode against the values the counters are about to take, so pulses
        // line up with the counters; a starting frame uses the live Prescale.
        p_act   = start ? Prescale : p_q;
        frame_n = (state == ST_COUNT) && (state_n == ST_COUNT) &&
                  (edge_n == p_last) && (bit_n == len_m1);
    end

    uart_rx_sample_gen #(
        .PRESCALE_WIDTH(PRESCALE_WIDTH)
    ) u_sample_gen (
        .active       (state_n == ST_COUNT),
        .prescale     (p_act),
        .edge_cnt     (edge_n),
        .sample_pulse (sp_n),
        .sample_idx   (si_n),
        .bit_done     (bd_n)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            p_q          <= '0;
            dsel_q       <= 2'b00;
            par_q        <= 1'b0;
            stop2_q      <= 1'b0;
            edge_cnt     <= '0;
            bit_cnt      <= '0;
            sample_pulse <= 1'b0;
            sample_idx   <= 2'd0;
            bit_done     <= 1'b0;
            frame_done   <= 1'b0;
            busy         <= 1'b0;
            cfg_err      <= 1'b0;
        end else begin
            state        <= state_n;
            if (start) begin
                p_q     <= Prescale;
                dsel_q  <= data_sel;
                par_q   <= par_en;
                stop2_q <= stop2;
            end
            edge_cnt     <= edge_n;
            bit_cnt      <= bit_n;
            sample_pulse <= sp_n;
            sample_idx   <= si_n;
            bit_done     <= bd_n;
            frame_done   <= frame_n;
            busy         <= (state_n == ST_COUNT);
            cfg_err      <= cfg_n;
        end
    end

endmodule

// File: tb/tb_uart_rx_frame_timer.sv
// Self-checking bench for uart_rx_frame_timer: vector table, corner sequences, random frames.
// Reference model tracks a single frame-time index t and derives edge/bit arithmetically.
module tb_uart_rx_frame_timer;
    localparam int PW = 6;
    localparam int NB = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          enable = 1'b0;
    logic [PW-1:0] Prescale = 6'd8;
    logic [1:0]    data_sel = 2'b11;
    logic          par_en = 1'b0;
    logic          stop2 = 1'b0;
`ifdef UART_RX_FRAME_TIMER_RESYNC_EN
    logic          rx_resync = 1'b0;
`endif
    logic [PW-1:0] edge_cnt;
    logic [NB-1:0] bit_cnt;
    logic          sample_pulse, bit_done, frame_done, busy, cfg_err;
    logic [1:0]    sample_idx;

    always #5 clk = ~clk;

    uart_rx_frame_timer #(.PRESCALE_WIDTH(PW), .N_BITS(NB)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .Prescale(Prescale),
        .data_sel(data_sel), .par_en(par_en), .stop2(stop2),
`ifdef UART_RX_FRAME_TIMER_RESYNC_EN
        .rx_resync(rx_resync),
`endif
        .edge_cnt(edge_cnt), .bit_cnt(bit_cnt), .sample_pulse(sample_pulse),
        .sample_idx(sample_idx), .bit_done(bit_done), .frame_done(frame_done),
        .busy(busy), .cfg_err(cfg_err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: mode 0 idle, 1 counting, 2 holding.
    int m_mode = 0;
    int m_t    = 0;
    int m_P    = 8;
    int m_L    = 10;
    bit m_cfg  = 1'b0;

    function automatic int flen(input logic [1:0] ds, input logic p, input logic s2);
        return 1 + (5 + int'(ds)) + int'(p) + (s2 ? 2 : 1);
    endfunction

    // Packed as {cfg, busy, frame_done, bit_done, sample_idx, sample_pulse, bit_cnt, edge_cnt}
    function automatic logic [16:0] model_out();
        int e, b, c;
        logic sp;
        logic [1:0] si;
        if (m_mode != 1) return {m_cfg, 16'h0};
        e  = m_t % m_P;
        b  = m_t / m_P;
        c  = m_P / 2;
        sp = (e >= c - 1) && (e <= c + 1);
        si = sp ? 2'(e - (c - 1)) : 2'd0;
        return {m_cfg, 1'b1, (m_t == m_L * m_P - 1), (e == m_P - 1), si, sp, 4'(b), 6'(e)};
    endfunction

    function automatic logic [16:0] dut_out();
        return {cfg_err, busy, frame_done, bit_done, sample_idx, sample_pulse, bit_cnt, edge_cnt};
    endfunction

    task automatic check_vec(input string name, input logic [16:0] act, input logic [16:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h (cfg,busy,fd,bd,si,sp,bit,edge) required %h", name, $time, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic model_step();
        bit rs;
        rs = 1'b0;
`ifdef UART_RX_FRAME_TIMER_RESYNC_EN
        rs = rx_resync;
`endif
        if (!reset_n) begin
            m_mode = 0;
            m_cfg  = 1'b0;
        end else begin
            case (m_mode)
                0: if (enable) begin
                    if (Prescale >= 4) begin
                        m_mode = 1; m_t = 0; m_cfg = 1'b0;
                        m_P = int'(Prescale);
                        m_L = flen(data_sel, par_en, stop2);
                    end else begin
                        m_cfg = 1'b1; m_mode = 2;
                    end
                end
                1: if (!enable) m_mode = 0;
                   else if (m_t == m_L * m_P - 1) m_mode = 2;
                   else if (rs && m_t < m_P) m_t = 0;
                   else m_t++;
                default: if (!enable) m_mode = 0;
            endcase
        end
    endtask

    // One clock: advance model with the inputs the DUT sees, then compare after the edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_vec("model", dut_out(), model_out());
    endtask

    typedef struct {
        logic       rst_n, en;
        logic [5:0] p;
        logic [1:0] ds;
        logic       par, s2;
        int         n;
        logic [5:0] e_edge;
        logic [3:0] e_bit;
        logic       e_busy, e_fd, e_bd, e_sp;
        logic [1:0] e_si;
        logic       e_cfg;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic en, input logic [5:0] p,
                                input logic [1:0] ds, input logic par, input logic s2, input int n,
                                input logic [5:0] ee, input logic [3:0] eb, input logic ebusy,
                                input logic efd, input logic ebd, input logic esp,
                                input logic [1:0] esi, input logic ecfg);
        vec_t v;
        v.rst_n = r; v.en = en; v.p = p; v.ds = ds; v.par = par; v.s2 = s2; v.n = n;
        v.e_edge = ee; v.e_bit = eb; v.e_busy = ebusy; v.e_fd = efd; v.e_bd = ebd;
        v.e_sp = esp; v.e_si = esi; v.e_cfg = ecfg;
        return v;
    endfunction

    vec_t tbl [25];

    initial begin
        int cnt;
        bit seen;
        int ncyc;

        //            rst en  P  ds  par s2  n   edge bit busy fd bd sp si cfg
        tbl[0]  = mk(0, 0, 8, 3, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(1, 1, 8, 3, 0, 0, 1,  0, 0, 1, 0, 0, 0, 0, 0);
        tbl[2]  = mk(1, 1, 8, 3, 0, 0, 3,  3, 0, 1, 0, 0, 1, 0, 0);
        tbl[3]  = mk(1, 1, 8, 3, 0, 0, 1,  4, 0, 1, 0, 0, 1, 1, 0);
        tbl[4]  = mk(1, 1, 8, 3, 0, 0, 1,  5, 0, 1, 0, 0, 1, 2, 0);
        tbl[5]  = mk(1, 1, 8, 3, 0, 0, 1,  6, 0, 1, 0, 0, 0, 0, 0);
        tbl[6]  = mk(1, 1, 8, 3, 0, 0, 1,  7, 0, 1, 0, 1, 0, 0, 0);
        tbl[7]  = mk(1, 1, 8, 3, 0, 0, 1,  0, 1, 1, 0, 0, 0, 0, 0);
        tbl[8]  = mk(1, 1, 8, 3, 0, 0, 70, 6, 9, 1, 0, 0, 0, 0, 0);
        tbl[9]  = mk(1, 1, 8, 3, 0, 0, 1,  7, 9, 1, 1, 1, 0, 0, 0);
        tbl[10] = mk(1, 1, 8, 3, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0);
        tbl[11] = mk(1, 1, 8, 3, 0, 0, 3,  0, 0, 0, 0, 0, 0, 0, 0);
        tbl[12] = mk(1, 0, 8, 3, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0);
        tbl[13] = mk(1, 1, 3, 3, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 1);
        tbl[14] = mk(1, 1, 3, 3, 0, 0, 2,  0, 0, 0, 0, 0, 0, 0, 1);
        tbl[15] = mk(1, 0, 3, 3, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 1);
        tbl[16] = mk(1, 1, 8, 3, 0, 0, 1,  0, 0, 1, 0, 0, 0, 0, 0);
        tbl[17] = mk(1, 1, 3, 3, 0, 0, 1,  1, 0, 1, 0, 0, 0, 0, 0);
        tbl[18] = mk(1, 0, 8, 3, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0);
        tbl[19] = mk(1, 1, 5, 0, 0, 0, 1,  0, 0, 1, 0, 0, 0, 0, 0);
        tbl[20] = mk(1, 1, 5, 0, 0, 0, 1,  1, 0, 1, 0, 0, 1, 0, 0);
        tbl[21] = mk(1, 1, 5, 0, 0, 0, 2,  3, 0, 1, 0, 0, 1, 2, 0);
        tbl[22] = mk(1, 1, 5, 0, 0, 0, 1,  4, 0, 1, 0, 1, 0, 0, 0);
        tbl[23] = mk(1, 1, 5, 0, 0, 0, 30, 4, 6, 1, 1, 1, 0, 0, 0);
        tbl[24] = mk(1, 0, 5, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 25; i++) begin
            reset_n  = tbl[i].rst_n;
            enable   = tbl[i].en;
            Prescale = tbl[i].p;
            data_sel = tbl[i].ds;
            par_en   = tbl[i].par;
            stop2    = tbl[i].s2;
            repeat (tbl[i].n) tick();
            check_vec($sformatf("vec%0d", i), dut_out(),
                      {tbl[i].e_cfg, tbl[i].e_busy, tbl[i].e_fd, tbl[i].e_bd,
                       tbl[i].e_si, tbl[i].e_sp, tbl[i].e_bit, tbl[i].e_edge});
        end

        // 5E2 at P=16: L=9, 144 busy cycles; Prescale change mid-frame ignored.
        Prescale = 6'd16; data_sel = 2'b00; par_en = 1'b1; stop2 = 1'b1; enable = 1'b1;
        cnt = 0; seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            if (i == 40) Prescale = 6'd8;
            tick();
            if (busy) cnt++;
            if (frame_done) begin
                seen = 1'b1;
                check_vec("5e2_end", {7'h0, bit_cnt, edge_cnt}, {7'h0, 4'd8, 6'd15});
            end
        end
        check_int("5e2_seen", int'(seen), 1);
        check_int("5e2_len", cnt, 144);
        enable = 1'b0; tick();

        // Abort at bit 4, edge 2 (8N1, P=8).
        Prescale = 6'd8; data_sel = 2'b11; par_en = 1'b0; stop2 = 1'b0; enable = 1'b1;
        tick();
        repeat (34) tick();
        check_vec("abort_pos", {7'h0, bit_cnt, edge_cnt}, {7'h0, 4'd4, 6'd2});
        enable = 1'b0; tick();
        check_vec("abort_out", dut_out(), 17'h0);

        // Reset mid-frame at bit 6, then full-length restart.
        enable = 1'b1; tick();
        repeat (48) tick();
        check_int("rst_pos_bit", int'(bit_cnt), 6);
        reset_n = 1'b0; tick();
        check_vec("rst_out", dut_out(), 17'h0);
        reset_n = 1'b1;
        cnt = 0; seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            tick();
            if (busy) cnt++;
            if (frame_done) seen = 1'b1;
        end
        check_int("rst_restart_len", cnt, 80);
        enable = 1'b0; tick();

`ifdef UART_RX_FRAME_TIMER_RESYNC_EN
        // Resync on the start bit shifts the frame by 6; resync on bit 3 is ignored.
        Prescale = 6'd16; enable = 1'b1;
        tick(); cnt = 1;
        repeat (5) begin tick(); cnt++; end
        check_int("rs_pre_edge", int'(edge_cnt), 5);
        rx_resync = 1'b1; tick(); cnt++; rx_resync = 1'b0;
        check_vec("rs_post", {7'h0, bit_cnt, edge_cnt}, {7'h0, 4'd0, 6'd0});
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            if (bit_cnt == 4'd3 && edge_cnt == 6'd5) begin
                rx_resync = 1'b1; tick(); rx_resync = 1'b0;
                check_int("rs_ignored_edge", int'(edge_cnt), 6);
            end else begin
                tick();
            end
            if (busy) cnt++;
            if (frame_done) seen = 1'b1;
        end
        check_int("rs_len", cnt, 166);
        enable = 1'b0; tick();
`endif

        // Random frames, aborts, mid-frame input changes and occasional resets.
        for (int f = 0; f < 60; f++) begin
            Prescale = 6'($urandom_range(2, 20));
            data_sel = 2'($urandom_range(0, 3));
            par_en   = 1'($urandom_range(0, 1));
            stop2    = 1'($urandom_range(0, 1));
            enable   = 1'b1;
            ncyc     = $urandom_range(1, 300);
            for (int c = 0; c < ncyc; c++) begin
                if ($urandom_range(0, 15) == 0) begin
                    Prescale = 6'($urandom_range(2, 20));
                    data_sel = 2'($urandom_range(0, 3));
                    par_en   = 1'($urandom_range(0, 1));
                    stop2    = 1'($urandom_range(0, 1));
                end
`ifdef UART_RX_FRAME_TIMER_RESYNC_EN
                rx_resync = ($urandom_range(0, 7) == 0);
`endif
                if ($urandom_range(0, 199) == 0) begin
                    reset_n = 1'b0; tick(); reset_n = 1'b1;
                end else begin
                    tick();
                end
            end
`ifdef UART_RX_FRAME_TIMER_RESYNC_EN
            rx_resync = 1'b0;
`endif
            enable = 1'b0;
            repeat ($urandom_range(1, 3)) tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
